// File: rtl/cone_vector_driver_if.sv
// Serial stimulus stream into the cone driver: one bit per valid/ready handshake.
// A bit transfers on a rising clock edge where s_valid and s_ready are both high; s_data is MSB-first.
interface cone_vector_driver_if;
  logic s_valid;
  logic s_data;
  logic s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/cone_vector_driver.sv
// Tester-side driver for a single-output combinational cone: deserialises a vector,
// holds it for a settle time, then folds the cone response into a SISR signature.
module cone_vector_driver #(
  parameter int              NUM_IN = 13,
  parameter int              SETTLE = 2,
  parameter int              SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 clear,
  cone_vector_driver_if.slave  s_if,
  output logic [NUM_IN-1:0]    cone_in,
  input  logic                 cone_out,
  output logic [SIG_W-1:0]     signature,
  output logic [15:0]          vec_count,
  output logic                 vec_done,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = $clog2(NUM_IN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_IN - 1);
  localparam logic [7:0]       LAST_SETTLE = 8'(SETTLE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_APPLY, ST_CAPTURE} state_t;

  state_t             state_q;
  logic [NUM_IN-1:0]  shreg_q;
  logic [NUM_IN-1:0]  shreg_d;
  logic [NUM_IN-1:0]  cone_in_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [7:0]         settle_cnt_q;
  logic [SIG_W-1:0]   signature_q;
  logic [SIG_W-1:0]   signature_d;
  logic [15:0]        vec_count_q;
  logic [15:0]        vec_count_d;
  logic               vec_done_q;
  logic               capture;

  assign shreg_d = {shreg_q[NUM_IN-2:0], s_if.s_data};
  assign capture = (state_q == ST_CAPTURE) && !abort;

  // abort keeps signature/count untouched and also masks a simultaneous clear.
  always_comb begin
    signature_d = signature_q;
    vec_count_d = vec_count_q;
    if (!abort && clear) begin
      signature_d = SEED;
      vec_count_d = '0;
    end else if (capture) begin
      signature_d = {signature_q[SIG_W-2:0], 1'b0} ^
                    ((signature_q[SIG_W-1] ^ cone_out) ? POLY : '0);
      vec_count_d = (vec_count_q == 16'hFFFF) ? vec_count_q : vec_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      cone_in_q    <= '0;
      bit_cnt_q    <= '0;
      settle_cnt_q <= '0;
      signature_q  <= SEED;
      vec_count_q  <= '0;
      vec_done_q   <= 1'b0;
    end else begin
      signature_q <= signature_d;
      vec_count_q <= vec_count_d;
      vec_done_q  <= capture && !clear;
      if (abort) begin
        state_q      <= ST_IDLE;
        bit_cnt_q    <= '0;
        settle_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q   <= ST_SHIFT;
              bit_cnt_q <= '0;
            end
          end
          ST_SHIFT: begin
            if (s_if.s_valid) begin
              shreg_q <= shreg_d;
              if (bit_cnt_q == LAST_BIT) begin
                cone_in_q    <= shreg_d;
                bit_cnt_q    <= '0;
                settle_cnt_q <= '0;
                state_q      <= ST_APPLY;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
          ST_APPLY: begin
            settle_cnt_q <= settle_cnt_q + 8'd1;
            if (settle_cnt_q == LAST_SETTLE) state_q <= ST_CAPTURE;
          end
          ST_CAPTURE: state_q <= ST_SHIFT;
          default:    state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign s_if.s_ready = (state_q == ST_SHIFT);
  assign cone_in      = cone_in_q;
  assign signature    = signature_q;
  assign vec_count    = vec_count_q;
  assign vec_done     = vec_done_q;
  assign busy         = (state_q != ST_IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cone_vector_driver.sv
// Directed bench for cone_vector_driver: a cycle-level behavioural model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_cone_vector_driver;

  localparam int              NUM_IN = 13;
  localparam int              SETTLE = 2;
  localparam int              SIG_W  = 16;
  localparam logic [15:0]     POLY   = 16'h1021;
  localparam logic [15:0]     SEED   = 16'h0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic start = 1'b0, abort = 1'b0, clear = 1'b0, cone_out = 1'b0;
  logic [NUM_IN-1:0] cone_in;
  logic [SIG_W-1:0]  signature;
  logic [15:0]       vec_count;
  logic              vec_done, busy;
  logic [1:0]        dbg_state;

  cone_vector_driver_if s_if ();

  cone_vector_driver #(
    .NUM_IN(NUM_IN), .SETTLE(SETTLE), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .clear(clear),
    .s_if(s_if), .cone_in(cone_in), .cone_out(cone_out), .signature(signature),
    .vec_count(vec_count), .vec_done(vec_done), .busy(busy), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: vector assembly, a countdown to the capture edge, SISR math.
  localparam logic [63:0] MASK = (64'd1 << NUM_IN) - 64'd1;
  logic        m_busy = 1'b0;
  int          m_bits = 0;
  int          m_wait = -1;
  logic [63:0] m_vec = '0;
  logic [63:0] m_cone = '0;
  logic [15:0] m_sig = SEED;
  logic [15:0] m_cnt = '0;
  logic        m_done = 1'b0;

  initial forever begin
    logic cap;
    logic fb;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0; m_bits = 0; m_wait = -1; m_vec = '0; m_cone = '0;
      m_sig = SEED; m_cnt = '0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (abort) begin
        m_busy = 1'b0; m_bits = 0; m_wait = -1;
      end else begin
        cap = 1'b0;
        if (m_busy && m_wait > 0) begin
          m_wait--;
          if (m_wait == 0) begin cap = 1'b1; m_wait = -1; end
        end else if (!m_busy) begin
          if (start) begin m_busy = 1'b1; m_bits = 0; end
        end else if (s_if.s_valid) begin
          m_vec = ((m_vec << 1) | 64'(s_if.s_data)) & MASK;
          m_bits++;
          if (m_bits == NUM_IN) begin m_cone = m_vec; m_bits = 0; m_wait = SETTLE + 1; end
        end
        if (clear) begin
          m_sig = SEED; m_cnt = '0;
        end else if (cap) begin
          fb = m_sig[15] ^ cone_out;
          m_sig = (m_sig << 1) ^ (fb ? POLY : 16'h0000);
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          m_done = 1'b1;
        end
      end
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cyc_cone_in",   64'(cone_in),      m_cone);
      check("cyc_signature", 64'(signature),    64'(m_sig));
      check("cyc_vec_count", 64'(vec_count),    64'(m_cnt));
      check("cyc_vec_done",  64'(vec_done),     64'(m_done));
      check("cyc_busy",      64'(busy),         64'(m_busy));
      check("cyc_s_ready",   64'(s_if.s_ready), 64'(m_busy && m_wait < 0));
    end
  end

  initial forever begin
    @(negedge clk);
    if (vec_done === 1'b1) done_cnt++;
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();  start = 1'b1; tick(); start = 1'b0; endtask
  task automatic pulse_abort();  abort = 1'b1; tick(); abort = 1'b0; endtask
  task automatic pulse_clear();  clear = 1'b1; tick(); clear = 1'b0; endtask

  // Sends the top n bits of v, MSB first; returns at the negedge after the last handshake.
  task automatic send_bits(input logic [NUM_IN-1:0] v, input int n, input int gap);
    int   k;
    logic ok;
    for (int i = NUM_IN - 1; i >= NUM_IN - n; i--) begin
      if (gap > 0) begin
        s_if.s_valid = 1'b0;
        tick(gap);
      end
      s_if.s_valid = 1'b1;
      s_if.s_data  = v[i];
      k = 0;
      while (s_if.s_ready !== 1'b1 && k < 50) begin tick(); k++; end
      ok = (k < 50);
      if (!ok) begin
        check("send_ready_timeout", 64'(ok), 64'd1);
        break;
      end
      tick();
    end
    s_if.s_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    logic seen;
    lat = 0;
    while (vec_done !== 1'b1 && lat < 40) begin tick(); lat++; end
    seen = (vec_done === 1'b1);
    check("vec_done_timeout", 64'(seen), 64'd1);
  endtask

  initial begin
    int lat;
    int base;
    s_if.s_valid = 1'b0;
    s_if.s_data  = 1'b0;

    #1 rst_n = 1'b0;
    tick(2);
    chk_en = 1'b1;
    check("rst_signature", 64'(signature), 64'h0000);
    check("rst_vec_count", 64'(vec_count), 64'h0);
    check("rst_cone_in",   64'(cone_in),   64'h0);
    check("rst_busy",      64'(busy),      64'h0);
    check("rst_s_ready",   64'(s_if.s_ready), 64'h0);
    rst_n = 1'b1;
    tick();

    // single all-ones vector, cone_out=1
    cone_out = 1'b1;
    pulse_start();
    send_bits(13'h1FFF, NUM_IN, 0);
    check("t1_cone_in", 64'(cone_in), 64'h1FFF);
    wait_done(lat);
    check("t1_latency",   64'(lat),       64'd3);
    check("t1_signature", 64'(signature), 64'h1021);
    check("t1_count",     64'(vec_count), 64'd1);

    // two vectors from a cleared signature
    pulse_clear();
    base = done_cnt;
    send_bits(13'h1FFF, NUM_IN, 0);
    wait_done(lat);
    check("t2_sig_first", 64'(signature), 64'h1021);
    tick();
    send_bits(13'h0F0F, NUM_IN, 0);
    wait_done(lat);
    check("t2_sig_second", 64'(signature), 64'h3063);
    check("t2_count",      64'(vec_count), 64'd2);
    tick();
    check("t2_pulses",     64'(done_cnt - base), 64'd2);

    // 0A5A with a gappy stream, cone_out=0
    pulse_abort();
    pulse_clear();
    cone_out = 1'b0;
    pulse_start();
    send_bits(13'h0A5A, NUM_IN, 1);
    check("t3_s_ready_apply", 64'(s_if.s_ready), 64'h0);
    wait_done(lat);
    check("t3_cone_in",   64'(cone_in),   64'h0A5A);
    check("t3_signature", 64'(signature), 64'h0000);
    check("t3_count",     64'(vec_count), 64'd1);

    // abort a partial vector, then a full 0001
    tick();
    send_bits(13'h1FFF, 7, 0);
    pulse_abort();
    check("t4_cone_held", 64'(cone_in), 64'h0A5A);
    check("t4_busy",      64'(busy),    64'h0);
    pulse_start();
    send_bits(13'h0001, NUM_IN, 0);
    wait_done(lat);
    check("t4_cone_in", 64'(cone_in),   64'h0001);
    check("t4_count",   64'(vec_count), 64'd2);

    // clear on the capture cycle with a saturated count
    tick();
    force dut.vec_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(posedge clk);
    #1 release dut.vec_count_q;
    tick();
    check("t5_preload", 64'(vec_count), 64'hFFFF);
    cone_out = 1'b1;
    send_bits(13'h1234, NUM_IN, 0);
    tick(2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_clear_count", 64'(vec_count), 64'h0);
    check("t5_clear_sig",   64'(signature), 64'(SEED));
    check("t5_clear_done",  64'(vec_done),  64'h0);

    // saturation with no clear
    tick();
    force dut.vec_count_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(posedge clk);
    #1 release dut.vec_count_q;
    tick();
    send_bits(13'h0777, NUM_IN, 0);
    wait_done(lat);
    check("t5_sat_count", 64'(vec_count), 64'hFFFF);
    check("t5_sat_sig",   64'(signature), 64'h1021);

    // async reset in the middle of APPLY
    tick();
    send_bits(13'h1ABC, NUM_IN, 0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy",    64'(busy),      64'h0);
    check("t6_rst_cone_in", 64'(cone_in),   64'h0);
    check("t6_rst_count",   64'(vec_count), 64'h0);
    check("t6_rst_sig",     64'(signature), 64'(SEED));
    tick();
    rst_n = 1'b1;
    base = done_cnt;
    tick(10);
    check("t6_no_done", 64'(done_cnt - base), 64'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
